cmd_cfg: RTL and testbench

//  Command processor directly downstream of the UART command wrapper in QuadCopter.

---
 rtl/cmd_cfg_pkg.sv | 24 ++
 rtl/cmd_cfg_timer.sv | 33 +++
 rtl/cmd_cfg.sv | 178 +++++++++++++++++
 tb/tb_cmd_cfg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_cfg_pkg.sv
// Shared types for the QuadCopter command processor: opcodes, FSM states and response bytes.
package cmd_cfg_pkg;

  typedef enum logic [7:0] {
    SET_PTCH  = 8'h02,
    SET_ROLL  = 8'h03,
    SET_YAW   = 8'h04,
    SET_THRST = 8'h05,
    CALIBRATE = 8'h06,
    EMER_LAND = 8'h07,
    MTRS_OFF  = 8'h08
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SPINUP,
    CAL,
    WAIT_SENT
  } state_t;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

endpackage

// File: rtl/cmd_cfg_timer.sv
// Saturating up-counter with synchronous clear; full is high while the count is all ones.
module cmd_cfg_timer #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic full
);

  logic [W-1:0] cnt_q, cnt_d;

  assign full = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !full) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_cfg.sv
// Command processor: decodes UART packets into setpoints, sequences spin-up/calibration, returns ACK/NAK.
// Define CMD_WDOG_EN to add a loss-of-link watchdog that forces an emergency landing.
module cmd_cfg
  import cmd_cfg_pkg::*;
#(
  parameter int SPINUP_W = 25,
  parameter int WDOG_W   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        resp_sent,
  output logic [15:0] ptch,
  output logic [15:0] roll,
  output logic [15:0] yaw,
  output logic [8:0]  thrst,
  output logic        inertial_cal,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic        motors_off
);

  state_t      state_q, state_d;
  logic [15:0] ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
  logic [8:0]  thrst_q, thrst_d;
  logic [7:0]  resp_q, resp_d;
  logic        motors_off_q, motors_off_d;
  logic        inertial_cal_q, inertial_cal_d;
  logic        strt_cal_q, strt_cal_d;
  logic        send_resp_q, send_resp_d;
  logic        spin_clr, spin_full, wdog_fire;

  cmd_cfg_timer #(.W(SPINUP_W)) u_spin (
    .clk  (clk),
    .rst  (rst),
    .clr  (spin_clr),
    .en   (state_q == SPINUP),
    .full (spin_full)
  );

`ifdef CMD_WDOG_EN
  // Any consumed packet proves the link is alive; the count only runs while motors may spin.
  cmd_cfg_timer #(.W(WDOG_W)) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_cmd_rdy),
    .en   (!motors_off_q),
    .full (wdog_fire)
  );
`else
  localparam int unused_wdog_w = WDOG_W;
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cmd_rdy) state_d = (cmd_t'(cmd) == CALIBRATE) ? SPINUP : WAIT_SENT;
      SPINUP:    if (spin_full) state_d = CAL;
      CAL:       if (cal_done) state_d = WAIT_SENT;
      WAIT_SENT: if (resp_sent) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ptch_d         = ptch_q;
    roll_d         = roll_q;
    yaw_d          = yaw_q;
    thrst_d        = thrst_q;
    resp_d         = resp_q;
    motors_off_d   = motors_off_q;
    inertial_cal_d = inertial_cal_q;
    strt_cal_d     = 1'b0;
    send_resp_d    = 1'b0;
    spin_clr       = 1'b0;
    clr_cmd_rdy    = 1'b0;
    // A watchdog landing yields to a command decoded in the same cycle.
    if (wdog_fire) begin
      ptch_d  = '0;
      roll_d  = '0;
      yaw_d   = '0;
      thrst_d = '0;
    end
    case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          resp_d      = ACK;
          send_resp_d = 1'b1;
          case (cmd_t'(cmd))
            SET_PTCH:  ptch_d  = data;
            SET_ROLL:  roll_d  = data;
            SET_YAW:   yaw_d   = data;
            SET_THRST: thrst_d = data[8:0];
            EMER_LAND: begin
              ptch_d  = '0;
              roll_d  = '0;
              yaw_d   = '0;
              thrst_d = '0;
            end
            MTRS_OFF: begin
              motors_off_d = 1'b1;
              thrst_d      = '0;
            end
            CALIBRATE: begin
              resp_d         = resp_q;
              send_resp_d    = 1'b0;
              motors_off_d   = 1'b0;
              inertial_cal_d = 1'b1;
              spin_clr       = 1'b1;
            end
            default: resp_d = NAK;
          endcase
        end
      end
      SPINUP: begin
        if (spin_full) strt_cal_d = 1'b1;
      end
      CAL: begin
        if (cal_done) begin
          inertial_cal_d = 1'b0;
          resp_d         = ACK;
          send_resp_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptch_q         <= '0;
      roll_q         <= '0;
      yaw_q          <= '0;
      thrst_q        <= '0;
      resp_q         <= '0;
      motors_off_q   <= 1'b1;
      inertial_cal_q <= 1'b0;
      strt_cal_q     <= 1'b0;
      send_resp_q    <= 1'b0;
    end else begin
      ptch_q         <= ptch_d;
      roll_q         <= roll_d;
      yaw_q          <= yaw_d;
      thrst_q        <= thrst_d;
      resp_q         <= resp_d;
      motors_off_q   <= motors_off_d;
      inertial_cal_q <= inertial_cal_d;
      strt_cal_q     <= strt_cal_d;
      send_resp_q    <= send_resp_d;
    end
  end

  assign ptch         = ptch_q;
  assign roll         = roll_q;
  assign yaw          = yaw_q;
  assign thrst        = thrst_q;
  assign resp         = resp_q;
  assign motors_off   = motors_off_q;
  assign inertial_cal = inertial_cal_q;
  assign strt_cal     = strt_cal_q;
  assign send_resp    = send_resp_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// Self-checking bench for cmd_cfg: table vectors, hand-written calibration/busy/reset sequences, random commands.
// Setpoint expectations after a long idle follow CMD_WDOG_EN.
module tb_cmd_cfg;

  localparam int SPINUP_W = 4;
  localparam int WDOG_W   = 6;

  logic        clk;
  logic        rst;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic [15:0] ptch, roll, yaw;
  logic [8:0]  thrst;
  logic        inertial_cal;
  logic        strt_cal;
  logic        cal_done;
  logic        motors_off;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_ptch, m_roll, m_yaw;
  logic [8:0]  m_thrst;
  logic        m_motors_off;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  resp;
    logic [15:0] ptch;
    logic [15:0] roll;
    logic [15:0] yaw;
    logic [8:0]  thrst;
    logic        motors_off;
  } vec_t;

  vec_t vecs[8];

  cmd_cfg #(.SPINUP_W(SPINUP_W), .WDOG_W(WDOG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_rdy      (cmd_rdy),
    .cmd          (cmd),
    .data         (data),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .resp         (resp),
    .send_resp    (send_resp),
    .resp_sent    (resp_sent),
    .ptch         (ptch),
    .roll         (roll),
    .yaw          (yaw),
    .thrst        (thrst),
    .inertial_cal (inertial_cal),
    .strt_cal     (strt_cal),
    .cal_done     (cal_done),
    .motors_off   (motors_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, expected to have finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_setpoints(input logic [15:0] ep, input logic [15:0] er, input logic [15:0] ey,
                                 input logic [8:0] et, input logic emo);
    checkOutput("ptch", ptch, ep);
    checkOutput("roll", roll, er);
    checkOutput("yaw", yaw, ey);
    checkOutput("thrst", thrst, et);
    checkOutput("motors_off", motors_off, emo);
  endtask

  // Reference model: the effect of one consumed packet on the flight setpoints.
  task automatic model_apply(input logic [7:0] c, input logic [15:0] d, output logic [7:0] r);
    r = 8'hA5;
    case (c)
      8'h02: m_ptch = d;
      8'h03: m_roll = d;
      8'h04: m_yaw = d;
      8'h05: m_thrst = d[8:0];
      8'h06: m_motors_off = 1'b0;
      8'h07: begin
        m_ptch = 16'h0; m_roll = 16'h0; m_yaw = 16'h0; m_thrst = 9'h0;
      end
      8'h08: begin
        m_motors_off = 1'b1; m_thrst = 9'h0;
      end
      default: r = 8'hEE;
    endcase
  endtask

  task automatic model_reset();
    m_ptch = 16'h0; m_roll = 16'h0; m_yaw = 16'h0; m_thrst = 9'h0; m_motors_off = 1'b1;
  endtask

  // Deliver one non-calibrate packet, then check response and setpoints, then finish the handshake.
  task automatic applyStimulus(input logic [7:0] c, input logic [15:0] d, input logic [7:0] exp_resp,
                               input logic [15:0] ep, input logic [15:0] er, input logic [15:0] ey,
                               input logic [8:0] et, input logic emo);
    int n;
    cmd = c;
    data = d;
    cmd_rdy = 1'b1;
    #1;
    n = 0;
    while (!clr_cmd_rdy && n < 50) begin
      next_cycle();
      n++;
    end
    checkOutput("clr_cmd_rdy", clr_cmd_rdy, 1'b1);
    next_cycle();
    cmd_rdy = 1'b0;
    checkOutput("send_resp", send_resp, 1'b1);
    checkOutput("resp", resp, exp_resp);
    check_setpoints(ep, er, ey, et, emo);
    next_cycle();
    checkOutput("send_resp_pulse", send_resp, 1'b0);
    resp_sent = 1'b1;
    next_cycle();
    resp_sent = 1'b0;
  endtask

  task automatic send_model(input logic [7:0] c, input logic [15:0] d);
    logic [7:0] r;
    model_apply(c, d, r);
    applyStimulus(c, d, r, m_ptch, m_roll, m_yaw, m_thrst, m_motors_off);
  endtask

  initial begin
    int n;
    bit saw_resp;
    logic [7:0] r;
    logic [7:0] c;

    rst = 1'b1; cmd_rdy = 1'b0; cmd = 8'h0; data = 16'h0; resp_sent = 1'b0; cal_done = 1'b0;
    model_reset();
    repeat (3) next_cycle();
    check_setpoints(16'h0, 16'h0, 16'h0, 9'h0, 1'b1);
    checkOutput("rst_send_resp", send_resp, 1'b0);
    checkOutput("rst_inertial_cal", inertial_cal, 1'b0);
    checkOutput("rst_resp", resp, 8'h00);
    rst = 1'b0;
    next_cycle();

    vecs[0] = '{8'h02, 16'h0123, 8'hA5, 16'h0123, 16'h0000, 16'h0000, 9'h000, 1'b1};
    vecs[1] = '{8'h03, 16'hFF00, 8'hA5, 16'h0123, 16'hFF00, 16'h0000, 9'h000, 1'b1};
    vecs[2] = '{8'h05, 16'h01FF, 8'hA5, 16'h0123, 16'hFF00, 16'h0000, 9'h1FF, 1'b1};
    vecs[3] = '{8'h04, 16'h8000, 8'hA5, 16'h0123, 16'hFF00, 16'h8000, 9'h1FF, 1'b1};
    vecs[4] = '{8'h05, 16'hFE0A, 8'hA5, 16'h0123, 16'hFF00, 16'h8000, 9'h00A, 1'b1};
    vecs[5] = '{8'h09, 16'h8991, 8'hEE, 16'h0123, 16'hFF00, 16'h8000, 9'h00A, 1'b1};
    vecs[6] = '{8'h07, 16'hABCD, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};
    vecs[7] = '{8'h02, 16'h7FFF, 8'hA5, 16'h7FFF, 16'h0000, 16'h0000, 9'h000, 1'b1};

    for (int i = 0; i < 8; i++) begin
      model_apply(vecs[i].cmd, vecs[i].data, r);
      applyStimulus(vecs[i].cmd, vecs[i].data, vecs[i].resp, vecs[i].ptch, vecs[i].roll,
                    vecs[i].yaw, vecs[i].thrst, vecs[i].motors_off);
    end

    // Calibration with a packet arriving mid spin-up and a stray cal_done that must be ignored.
    cmd = 8'h06; data = 16'h0; cmd_rdy = 1'b1;
    #1;
    checkOutput("cal_clr_cmd_rdy", clr_cmd_rdy, 1'b1);
    next_cycle();
    cmd_rdy = 1'b0;
    m_motors_off = 1'b0;
    checkOutput("cal_inertial_on", inertial_cal, 1'b1);
    checkOutput("cal_motors_on", motors_off, 1'b0);
    checkOutput("cal_no_resp", send_resp, 1'b0);
    n = 0;
    while (!strt_cal && n < 200) begin
      if (n == 3) begin
        cmd = 8'h02; data = 16'h1111; cmd_rdy = 1'b1;
      end
      cal_done = (n == 5);
      next_cycle();
      n++;
      if (n == 4) checkOutput("busy_no_clr", clr_cmd_rdy, 1'b0);
    end
    cal_done = 1'b0;
    checkOutput("spinup_len", n, 32'd16);
    next_cycle();
    checkOutput("strt_cal_pulse", strt_cal, 1'b0);
    checkOutput("cal_inertial_hold", inertial_cal, 1'b1);
    checkOutput("cal_no_clr", clr_cmd_rdy, 1'b0);
    cal_done = 1'b1;
    next_cycle();
    cal_done = 1'b0;
    checkOutput("cal_inertial_off", inertial_cal, 1'b0);
    checkOutput("cal_send_resp", send_resp, 1'b1);
    checkOutput("cal_resp", resp, 8'hA5);
    resp_sent = 1'b1;
    #1;
    checkOutput("wait_no_clr", clr_cmd_rdy, 1'b0);
    next_cycle();
    resp_sent = 1'b0;
    checkOutput("pending_clr", clr_cmd_rdy, 1'b1);
    next_cycle();
    cmd_rdy = 1'b0;
    m_ptch = 16'h1111;
    checkOutput("pending_send_resp", send_resp, 1'b1);
    check_setpoints(m_ptch, m_roll, m_yaw, m_thrst, m_motors_off);
    next_cycle();
    resp_sent = 1'b1;
    next_cycle();
    resp_sent = 1'b0;

    // Long silence with motors running.
    saw_resp = 1'b0;
    repeat (100) begin
      next_cycle();
      if (send_resp) saw_resp = 1'b1;
    end
    checkOutput("idle_no_resp", saw_resp, 1'b0);
`ifdef CMD_WDOG_EN
    m_ptch = 16'h0; m_roll = 16'h0; m_yaw = 16'h0; m_thrst = 9'h0;
`endif
    check_setpoints(m_ptch, m_roll, m_yaw, m_thrst, m_motors_off);

    repeat (40) begin
      case ($urandom_range(0, 6))
        0: c = 8'h02;
        1: c = 8'h03;
        2: c = 8'h04;
        3: c = 8'h05;
        4: c = 8'h07;
        5: c = 8'h08;
        default: c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(9, 255));
      endcase
      send_model(c, 16'($urandom));
    end

    // Reset in the middle of spin-up.
    cmd = 8'h06; data = 16'h0; cmd_rdy = 1'b1;
    next_cycle();
    cmd_rdy = 1'b0;
    repeat (5) next_cycle();
    checkOutput("pre_rst_inertial", inertial_cal, 1'b1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    model_reset();
    check_setpoints(16'h0, 16'h0, 16'h0, 9'h0, 1'b1);
    checkOutput("mid_rst_inertial", inertial_cal, 1'b0);
    checkOutput("mid_rst_send_resp", send_resp, 1'b0);
    checkOutput("mid_rst_resp", resp, 8'h00);
    checkOutput("mid_rst_strt_cal", strt_cal, 1'b0);
    next_cycle();
    send_model(8'h02, 16'h2468);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
